// File: rtl/um_init_pkg.sv
// Package shared by the init sequencer and status-register decode.
// Holds the 3-bit FSM state encoding so software-visible state values
// and the RTL never drift apart.
package um_init_pkg;

  localparam int STATE_W = 3;

  // Encoding is fixed: status decode reads these raw values from state_o.
  typedef enum logic [STATE_W-1:0] {
    ST_WAIT    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

endpackage

// File: rtl/um_init_seq_sync_sig.sv
// sync_sig: brings one asynchronous level into the clk domain.
//   clk, rst_n   clock and asynchronous active-low reset
//   async_in     level from another clock domain
//   sync_out     AND of every shift-register tap
// Using the AND of all taps makes rises slow (SHIFT_WIDTH edges) and
// filters pulses shorter than SHIFT_WIDTH cycles, while a fall is seen
// after a single edge -- loss is reported quickly, recovery cautiously.
module sync_sig #(
  parameter int SHIFT_WIDTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SHIFT_WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shreg <= '0;
    else        shreg <= {shreg[SHIFT_WIDTH-2:0], async_in};
  end

  assign sync_out = &shreg;

endmodule

// File: rtl/um_init_seq.sv
// um_init_seq: power-up / recovery sequencer for the pipeline.
//   clk, rst_n          clock, asynchronous active-low reset
//   pll_lock_a          PLL locked (asynchronous)
//   link_up_a           link up (asynchronous)
//   soft_rst            synchronous restart request, acted on every cycle
//   stage_rst_n[N-1:0]  per-stage active-low resets, released 0..N-1
//   stage_en[N-1:0]     per-stage enables, all bits move together
//   init_done           high only in RUN
//   fault_cnt           saturating count of FAULT entries
//   state_o             current FSM state (um_init_pkg::state_e encoding)
// All outputs are registered. Priority: soft_rst > loss of ok > progression.
module um_init_seq
  import um_init_pkg::*;
#(
  parameter int NUM_STAGE     = 4,
  parameter int SYNC_WIDTH    = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int STEP_CYCLES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock_a,
  input  logic                 link_up_a,
  input  logic                 soft_rst,
  output logic [NUM_STAGE-1:0] stage_rst_n,
  output logic [NUM_STAGE-1:0] stage_en,
  output logic                 init_done,
  output logic [CNT_W-1:0]     fault_cnt,
  output logic [STATE_W-1:0]   state_o
);

  localparam int IDX_W = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGE - 1);

  logic pll_sync, link_sync, ok;

  sync_sig #(.SHIFT_WIDTH(SYNC_WIDTH)) u_pll_sync (
    .clk(clk), .rst_n(rst_n), .async_in(pll_lock_a), .sync_out(pll_sync)
  );

  sync_sig #(.SHIFT_WIDTH(SYNC_WIDTH)) u_link_sync (
    .clk(clk), .rst_n(rst_n), .async_in(link_up_a), .sync_out(link_sync)
  );

  assign ok = pll_sync & link_sync;

  state_e               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [NUM_STAGE-1:0] rst_n_d, en_d;
  logic                 done_d;
  logic [CNT_W-1:0]     fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT;
      cnt         <= '0;
      idx         <= '0;
      stage_rst_n <= '0;
      stage_en    <= '0;
      init_done   <= 1'b0;
      fault_cnt   <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      stage_rst_n <= rst_n_d;
      stage_en    <= en_d;
      init_done   <= done_d;
      fault_cnt   <= fault_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    rst_n_d = stage_rst_n;
    en_d    = stage_en;
    done_d  = init_done;
    fault_d = fault_cnt;

    if (soft_rst) begin
      // Restart wins over everything, including a simultaneous loss of ok:
      // no fault is counted for a requested restart.
      state_d = ST_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      en_d    = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          rst_n_d = '0;
          en_d    = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          if (ok) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!ok) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = NUM_STAGE'(1);
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!ok) begin
            // Tear down on the same edge that enters FAULT.
            state_d = ST_FAULT;
            cnt_d   = '0;
            rst_n_d = '0;
            en_d    = '0;
            done_d  = 1'b0;
            fault_d = (&fault_cnt) ? fault_cnt : fault_cnt + CNT_W'(1);
          end else if (state == ST_RELEASE) begin
            if (cnt == STEP_LAST) begin
              cnt_d = '0;
              if (idx == IDX_LAST) begin
                state_d = ST_RUN;
                en_d    = '1;
                done_d  = 1'b1;
              end else begin
                idx_d = idx + IDX_W'(1);
                // Shift in a one so released bits stay a contiguous low run.
                rst_n_d = (stage_rst_n << 1) | NUM_STAGE'(1);
              end
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end
        end
        ST_FAULT: begin
          // ok is deliberately ignored: the hold time always runs out.
          if (cnt == STEP_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          en_d    = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_um_init_seq.sv
// Directed bench for um_init_seq with default parameters.
module tb_um_init_seq;
  import um_init_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, pll_lock_a, link_up_a, soft_rst;
  logic [N-1:0] stage_rst_n, stage_en;
  logic         init_done;
  logic [7:0]   fault_cnt;
  logic [2:0]   state_o;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  um_init_seq dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_a(pll_lock_a), .link_up_a(link_up_a),
    .soft_rst(soft_rst), .stage_rst_n(stage_rst_n), .stage_en(stage_en),
    .init_done(init_done), .fault_cnt(fault_cnt), .state_o(state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // Expect all five output fields at once (state, rst, en, done, fault).
  task automatic expect_all(input logic [2:0] s, input logic [N-1:0] r,
                            input logic [N-1:0] en, input logic d, input logic [7:0] f);
    push(32'(s)); push(32'(r)); push(32'(en)); push(32'(d)); push(32'(f));
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state_o));
    check({tag, ".rst_n"}, 32'(stage_rst_n));
    check({tag, ".en"},    32'(stage_en));
    check({tag, ".done"},  32'(init_done));
    check({tag, ".fault"}, 32'(fault_cnt));
  endtask

  // Bounded wait for a state; an expired bound shows up as a state mismatch.
  task automatic wait_state(input string tag, input logic [2:0] s, input int bound);
    int k = 0;
    while (state_o !== s && k < bound) begin
      tick(1);
      k++;
    end
    push(32'(s));
    check(tag, 32'(state_o));
  endtask

  // Order/enable invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      tests++;
      assert ((stage_rst_n & (stage_rst_n + 1'b1)) == '0) else begin
        failed++;
        $error("FAIL inv_order observed=%b expected=contiguous low ones", stage_rst_n);
      end
      tests++;
      assert (stage_en == '0 || (stage_en == '1 && stage_rst_n == '1)) else begin
        failed++;
        $error("FAIL inv_enable observed en=%b rst_n=%b expected=en 0 or all released", stage_en, stage_rst_n);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; pll_lock_a = 1'b1; link_up_a = 1'b1; soft_rst = 1'b0;

    // 1. Reset holds everything at zero even with inputs high.
    tick(3);
    expect_all(ST_WAIT, 4'h0, 4'h0, 1'b0, 8'd0);
    check_all("reset");
    pll_lock_a = 1'b0; link_up_a = 1'b0;
    rst_n = 1'b1;
    tick(5);
    push(32'(ST_WAIT)); check("idle_after_reset", 32'(state_o));

    // 3. One-cycle link pulse with PLL high is filtered.
    pll_lock_a = 1'b1;
    link_up_a  = 1'b1; tick(1); link_up_a = 1'b0;
    tick(6);
    push(32'(ST_WAIT)); check("pulse_filtered", 32'(state_o));
    // Drop during SETTLE near cnt=10.
    link_up_a = 1'b1;
    tick(3);
    push(32'(ST_SETTLE)); check("settle_entry_a", 32'(state_o));
    tick(10);
    link_up_a = 1'b0;
    tick(2);
    expect_all(ST_WAIT, 4'h0, 4'h0, 1'b0, 8'd0);
    check_all("settle_drop");

    // 2. Full sequence from a fresh rise (restarts the 16 settle cycles).
    link_up_a = 1'b1;
    push(32'(ST_WAIT)); push(32'(ST_SETTLE));
    push(32'(ST_SETTLE)); push(32'h0);
    push(32'(ST_RELEASE)); push(32'h1);
    push(32'h3); push(32'h7); push(32'hF); push(32'h0);
    push(32'h0); push(32'h0);
    tick(2);  check("seq_wait_c2",   32'(state_o));
    tick(1);  check("seq_settle_c2", 32'(state_o));
    tick(15); check("seq_state_c17", 32'(state_o));
    check("seq_rst_c17", 32'(stage_rst_n));
    tick(1);  check("seq_state_c18", 32'(state_o));
    check("seq_rst_c18", 32'(stage_rst_n));
    tick(8);  check("seq_rst_c26", 32'(stage_rst_n));
    tick(8);  check("seq_rst_c34", 32'(stage_rst_n));
    tick(8);  check("seq_rst_c42", 32'(stage_rst_n));
    check("seq_en_c42", 32'(stage_en));
    tick(7);  check("seq_en_c49", 32'(stage_en));
    check("seq_done_c49", 32'(init_done));
    tick(1);
    expect_all(ST_RUN, 4'hF, 4'hF, 1'b1, 8'd0);
    check_all("seq_run_c50");

    // 4. Loss of PLL in RUN; ok returning during FAULT is ignored.
    tick(4);
    pll_lock_a = 1'b0;
    tick(2);
    expect_all(ST_FAULT, 4'h0, 4'h0, 1'b0, 8'd1);
    check_all("run_loss");
    pll_lock_a = 1'b1;
    tick(7);
    push(32'(ST_FAULT)); check("fault_hold", 32'(state_o));
    tick(1);
    push(32'(ST_WAIT)); check("fault_exit", 32'(state_o));
    tick(1);
    push(32'(ST_SETTLE)); check("reseq_settle", 32'(state_o));

    // 5. soft_rst during RELEASE while ok is already falling.
    pll_lock_a = 1'b0; link_up_a = 1'b0;
    tick(3);
    push(32'(ST_WAIT)); check("back_to_wait", 32'(state_o));
    pll_lock_a = 1'b1; link_up_a = 1'b1;
    tick(27);
    push(32'h3); check("soft_pre_rst", 32'(stage_rst_n));
    link_up_a = 1'b0;
    tick(1);
    push(32'(ST_RELEASE)); check("soft_pre_state", 32'(state_o));
    soft_rst = 1'b1;
    tick(1);
    expect_all(ST_WAIT, 4'h0, 4'h0, 1'b0, 8'd1);
    check_all("soft_rst");
    link_up_a = 1'b1;
    tick(5);
    push(32'(ST_WAIT)); check("soft_hold", 32'(state_o));
    soft_rst = 1'b0;
    tick(1);
    push(32'(ST_SETTLE)); check("soft_release", 32'(state_o));

    // Asynchronous reset mid-sequence, no clock edge needed.
    tick(20);
    push(32'h1); check("async_pre_rst", 32'(stage_rst_n));
    #2 rst_n = 1'b0;
    #1;
    expect_all(ST_WAIT, 4'h0, 4'h0, 1'b0, 8'd0);
    check_all("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 6. Saturation of the fault counter.
    for (int i = 0; i < 300; i++) begin
      pll_lock_a = 1'b1; link_up_a = 1'b1;
      wait_state("sat_release", ST_RELEASE, 40);
      pll_lock_a = 1'b0;
      wait_state("sat_wait", ST_WAIT, 20);
      if (i == 253) begin
        push(32'd254); check("sat_254", 32'(fault_cnt));
      end
    end
    push(32'd255); check("sat_255", 32'(fault_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
